// File: rtl/mem_arbiter_2p_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_arbiter_2p_if
// Brief    : Client request/response ports and memory pins of mem_arbiter_2p.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mem_arbiter_2p_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rsp_valid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rsp_valid;
  logic [DW-1:0] b_rdata;

  logic          mem_en;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata, mem_valid,
    output a_gnt, a_rsp_valid, a_rdata,
    output b_gnt, b_rsp_valid, b_rdata,
    output mem_en, mem_re, mem_addr, mem_wdata
  );

  // Clients plus memory side
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata, mem_valid,
    input  a_gnt, a_rsp_valid, a_rdata,
    input  b_gnt, b_rsp_valid, b_rdata,
    input  mem_en, mem_re, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_2p.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mem_arbiter_2p
// Brief    : Two-port arbiter/sequencer for a 16x32 synchronous memory.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter_2p #(
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_2p_if.slave  bus,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_resp  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_owner_b;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_last_b;
  logic          r_err;
  logic          w_pick_b;
  logic          w_grant;

  generate
    if (RR_EN) begin : g_rr
      // On a tie, the port not granted last wins
      assign w_pick_b = bus.b_req & (~bus.a_req | ~r_last_b);
    end else begin : g_fixed
      assign w_pick_b = bus.b_req & ~bus.a_req;
    end
  endgenerate

  // No grant while reset is held, so nothing is latched that reset would discard
  assign w_grant = (r_state == c_st_idle) && (bus.a_req || bus.b_req) && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_grant) w_state_nxt = c_st_issue;
      c_st_issue: w_state_nxt = c_st_resp;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    bus.a_gnt       = 1'b0;
    bus.b_gnt       = 1'b0;
    bus.a_rsp_valid = 1'b0;
    bus.b_rsp_valid = 1'b0;
    bus.a_rdata     = '0;
    bus.b_rdata     = '0;
    bus.mem_en      = 1'b0;
    bus.mem_re      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    case (r_state)
      c_st_idle: begin
        bus.a_gnt = w_grant & ~w_pick_b;
        bus.b_gnt = w_grant &  w_pick_b;
      end
      c_st_issue: begin
        bus.mem_en    = r_we;
        bus.mem_re    = ~r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_we ? r_wdata : '0;
      end
      c_st_resp: begin
        // Memory output was registered at the ISSUE edge, so it is current here
        if (r_owner_b) begin
          bus.b_rsp_valid = 1'b1;
          bus.b_rdata     = r_we ? '0 : bus.mem_rdata;
        end else begin
          bus.a_rsp_valid = 1'b1;
          bus.a_rdata     = r_we ? '0 : bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner_b <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_last_b  <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner_b <= w_pick_b;
        r_we      <= w_pick_b ? bus.b_we    : bus.a_we;
        r_addr    <= w_pick_b ? bus.b_addr  : bus.a_addr;
        r_wdata   <= w_pick_b ? bus.b_wdata : bus.a_wdata;
        r_last_b  <= w_pick_b;
      end
      if ((r_state == c_st_resp) && !r_we && !bus.mem_valid) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy = (r_state != c_st_idle);
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_2p.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mem_arbiter_2p
// Brief    : Directed bench for mem_arbiter_2p with a behavioural 16x32 memory.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter_2p;

  logic clk;
  logic rst;
  logic busy_rr, err_rr, busy_fp, err_fp;
  int   n_tests;
  int   n_fail;

  mem_arbiter_2p_if #(.AW(4), .DW(32)) bus_rr ();
  mem_arbiter_2p_if #(.AW(4), .DW(32)) bus_fp ();

  mem_arbiter_2p #(.AW(4), .DW(32), .RR_EN(1'b1)) dut_rr (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_rr),
    .busy (busy_rr),
    .err  (err_rr)
  );

  mem_arbiter_2p #(.AW(4), .DW(32), .RR_EN(1'b0)) dut_fp (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_fp),
    .busy (busy_fp),
    .err  (err_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reset first, then write priority, registered read data
  logic [31:0] r_mem [16];
  logic [31:0] r_dout;
  logic        r_vld;
  logic        force_invalid;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else if (bus_rr.mem_en) begin
      r_mem[bus_rr.mem_addr] <= bus_rr.mem_wdata;
      r_vld <= 1'b0;
    end else if (bus_rr.mem_re) begin
      r_dout <= r_mem[bus_rr.mem_addr];
      r_vld  <= 1'b1;
    end
  end

  assign bus_rr.mem_rdata = r_dout;
  assign bus_rr.mem_valid = r_vld & ~force_invalid;
  assign bus_fp.mem_rdata = '0;
  assign bus_fp.mem_valid = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_rr.a_req = 1'b0; bus_rr.a_we = 1'b0; bus_rr.a_addr = '0; bus_rr.a_wdata = '0;
    bus_rr.b_req = 1'b0; bus_rr.b_we = 1'b0; bus_rr.b_addr = '0; bus_rr.b_wdata = '0;
    bus_fp.a_req = 1'b0; bus_fp.a_we = 1'b0; bus_fp.a_addr = '0; bus_fp.a_wdata = '0;
    bus_fp.b_req = 1'b0; bus_fp.b_we = 1'b0; bus_fp.b_addr = '0; bus_fp.b_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One full transaction on bus_rr; ends at the falling edge of the RESP cycle
  task automatic do_txn(input logic pb, input logic we, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    @(posedge clk); #1;
    if (pb) begin
      bus_rr.b_req = 1'b1; bus_rr.b_we = we; bus_rr.b_addr = addr; bus_rr.b_wdata = wd;
    end else begin
      bus_rr.a_req = 1'b1; bus_rr.a_we = we; bus_rr.a_addr = addr; bus_rr.a_wdata = wd;
    end
    @(negedge clk);
    chk({tag, ".gnt"}, {30'd0, bus_rr.a_gnt, bus_rr.b_gnt}, pb ? 32'd1 : 32'd2);
    chk({tag, ".busy0"}, {31'd0, busy_rr}, 32'd0);
    @(posedge clk); #1;
    bus_rr.a_req = 1'b0;
    bus_rr.b_req = 1'b0;
    @(negedge clk);
    chk({tag, ".en_re"}, {30'd0, bus_rr.mem_en, bus_rr.mem_re}, we ? 32'd2 : 32'd1);
    chk({tag, ".maddr"}, {28'd0, bus_rr.mem_addr}, {28'd0, addr});
    chk({tag, ".mwdata"}, bus_rr.mem_wdata, we ? wd : 32'd0);
    chk({tag, ".busy1"}, {31'd0, busy_rr}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".rsp"}, {30'd0, bus_rr.a_rsp_valid, bus_rr.b_rsp_valid}, pb ? 32'd1 : 32'd2);
    chk({tag, ".rdata"}, pb ? bus_rr.b_rdata : bus_rr.a_rdata, we ? 32'd0 : exp_rd);
    chk({tag, ".xrdata"}, pb ? bus_rr.a_rdata : bus_rr.b_rdata, 32'd0);
    chk({tag, ".busy2"}, {31'd0, busy_rr}, 32'd1);
    chk({tag, ".idle_en"}, {31'd0, bus_rr.mem_en | bus_rr.mem_re}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp4;
    n_tests = 0;
    n_fail  = 0;
    force_invalid = 1'b0;
    rst = 1'b0;
    idle_inputs();

    // Reset state, including a request held during reset
    bus_rr.a_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst.outs", {26'd0, bus_rr.a_gnt, bus_rr.b_gnt, bus_rr.a_rsp_valid,
                     bus_rr.mem_en, busy_rr, err_rr}, 32'd0);
    chk("rst.addr", {28'd0, bus_rr.mem_addr}, 32'd0);
    @(posedge clk); #1;
    bus_rr.a_req = 1'b0;
    rst = 1'b1;

    do_txn(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 32'd0, "a_wr3");
    do_txn(1'b0, 1'b0, 4'd3, 32'd0, 32'hDEADBEEF, "a_rd3");
    chk("a_rd3.err", {31'd0, err_rr}, 32'd0);

    // Both ports hold read requests; round-robin vs fixed priority side by side
    do_reset();
    @(posedge clk); #1;
    bus_rr.a_req = 1'b1; bus_rr.a_addr = 4'd3;
    bus_rr.b_req = 1'b1; bus_rr.b_addr = 4'd5;
    bus_fp.a_req = 1'b1; bus_fp.b_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      // {a_gnt, b_gnt, a_rsp, b_rsp}: grant on phase 0, response on phase 2, A on even slots
      case (c)
        0, 6:    exp4 = 4'b1000;
        3, 9:    exp4 = 4'b0100;
        2, 8:    exp4 = 4'b0010;
        5, 11:   exp4 = 4'b0001;
        default: exp4 = 4'b0000;
      endcase
      chk($sformatf("rr.c%0d", c), {28'd0, bus_rr.a_gnt, bus_rr.b_gnt,
                                    bus_rr.a_rsp_valid, bus_rr.b_rsp_valid}, {28'd0, exp4});
      chk($sformatf("fp.c%0d", c), {30'd0, bus_fp.a_gnt, bus_fp.b_gnt},
          (c % 3 == 0) ? 32'd2 : 32'd0);
    end
    @(posedge clk); #1;
    idle_inputs();

    // Reset asserted while a write is in ISSUE
    @(posedge clk); #1;
    bus_rr.a_req = 1'b1; bus_rr.a_we = 1'b1; bus_rr.a_addr = 4'd7; bus_rr.a_wdata = 32'h12345678;
    @(negedge clk);
    chk("midrst.gnt", {31'd0, bus_rr.a_gnt}, 32'd1);
    @(posedge clk); #1;
    bus_rr.a_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.issue", {31'd0, bus_rr.mem_en}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.outs", {26'd0, bus_rr.a_gnt, bus_rr.a_rsp_valid, bus_rr.mem_en,
                        bus_rr.mem_re, busy_rr, err_rr}, 32'd0);
    chk("midrst.maddr", {28'd0, bus_rr.mem_addr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst.norsp", {31'd0, bus_rr.a_rsp_valid}, 32'd0);
    do_txn(1'b0, 1'b0, 4'd7, 32'd0, 32'd0, "a_rd7");

    // Fresh read, then a read whose valid is forced low
    do_reset();
    do_txn(1'b1, 1'b0, 4'd15, 32'd0, 32'd0, "b_rd15");
    @(posedge clk);
    @(negedge clk);
    chk("b_rd15.err", {31'd0, err_rr}, 32'd0);
    force_invalid = 1'b1;
    do_txn(1'b1, 1'b0, 4'd15, 32'd0, 32'd0, "b_inv");
    @(posedge clk); #1;
    force_invalid = 1'b0;
    @(negedge clk);
    chk("inv.err", {31'd0, err_rr}, 32'd1);
    do_txn(1'b0, 1'b1, 4'd1, 32'h00000055, 32'd0, "a_wr1");
    do_txn(1'b0, 1'b0, 4'd1, 32'd0, 32'h00000055, "a_rd1");
    chk("sticky.err", {31'd0, err_rr}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("clr.err", {31'd0, err_rr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
